// File: rtl/dat_serializer.sv
// dat_serializer: serializes N-bit words onto an M-line SD DAT bus, MSB nibble first, with start/stop framing.
// Per-line CRC16 (x^16+x^12+x^5+1) is appended when DAT_SERIALIZER_CRC16_EN is defined.
module dat_serializer #(
  parameter int N           = 32,
  parameter int M           = 4,
  parameter int BLOCK_WORDS = 128
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] word_in,
  input  logic         word_valid,
  output logic         word_ready,
  output logic [M-1:0] serial,
  output logic         serial_oe,
  output logic         busy,
  output logic         block_done,
  output logic         underrun
);

  localparam int NIBS   = N / M;
  localparam int NIB_W  = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int WORD_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [NIB_W-1:0]  NIB_LAST  = NIB_W'(NIBS - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(BLOCK_WORDS - 1);

`ifdef DAT_SERIALIZER_CRC16_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CRC, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic [N-1:0]      shreg_q, shreg_d;
  logic [NIB_W-1:0]  nib_q, nib_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [M-1:0]      serial_q, serial_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              urun_q, urun_d;
  logic              handshake;
`ifdef DAT_SERIALIZER_CRC16_EN
  logic [3:0]           crc_cnt_q, crc_cnt_d;
  logic [M-1:0][15:0]   crc_q, crc_d;
`endif

  always_comb begin
    word_ready = (state_q == S_START) ||
                 ((state_q == S_DATA) && (nib_q == NIB_LAST) && (word_q != WORD_LAST));
    handshake  = word_ready && word_valid;
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    nib_d   = nib_q;
    word_d  = word_q;
    done_d  = 1'b0;
    urun_d  = 1'b0;
`ifdef DAT_SERIALIZER_CRC16_EN
    crc_cnt_d = crc_cnt_q;
    crc_d     = crc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          nib_d   = '0;
          word_d  = '0;
`ifdef DAT_SERIALIZER_CRC16_EN
          crc_cnt_d = '0;
          crc_d     = '0;
`endif
        end
      end
      S_START: begin
        if (handshake) begin
          state_d = S_DATA;
          shreg_d = word_in;
        end else begin
          state_d = S_IDLE;
          urun_d  = 1'b1;
        end
      end
      S_DATA: begin
`ifdef DAT_SERIALIZER_CRC16_EN
        // line i carries bit i of the nibble currently on the bus
        for (int unsigned i = 0; i < M; i++) begin
          crc_d[i] = {crc_q[i][14:0], 1'b0} ^
                     ({16{crc_q[i][15] ^ shreg_q[N-M+i]}} & 16'h1021);
        end
`endif
        if (nib_q != NIB_LAST) begin
          nib_d   = nib_q + 1'b1;
          shreg_d = shreg_q << M;
        end else if (word_q == WORD_LAST) begin
`ifdef DAT_SERIALIZER_CRC16_EN
          state_d = S_CRC;
`else
          state_d = S_STOP;
`endif
        end else if (handshake) begin
          shreg_d = word_in;
          nib_d   = '0;
          word_d  = word_q + 1'b1;
        end else begin
          state_d = S_IDLE;
          urun_d  = 1'b1;
        end
      end
`ifdef DAT_SERIALIZER_CRC16_EN
      S_CRC: begin
        for (int unsigned i = 0; i < M; i++) begin
          crc_d[i] = {crc_q[i][14:0], 1'b0};
        end
        crc_cnt_d = crc_cnt_q + 1'b1;
        if (crc_cnt_q == 4'd15) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the bus pins come straight from flops.
  always_comb begin
    active_d = (state_d != S_IDLE);
    serial_d = '1;
    case (state_d)
      S_START: serial_d = '0;
      S_DATA:  serial_d = shreg_d[N-1 -: M];
`ifdef DAT_SERIALIZER_CRC16_EN
      S_CRC: begin
        for (int unsigned i = 0; i < M; i++) serial_d[i] = crc_d[i][15];
      end
`endif
      default: serial_d = '1;
    endcase
  end

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      nib_q    <= '0;
      word_q   <= '0;
      serial_q <= '1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      urun_q   <= 1'b0;
`ifdef DAT_SERIALIZER_CRC16_EN
      crc_cnt_q <= '0;
      crc_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      nib_q    <= nib_d;
      word_q   <= word_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
      urun_q   <= urun_d;
`ifdef DAT_SERIALIZER_CRC16_EN
      crc_cnt_q <= crc_cnt_d;
      crc_q     <= crc_d;
`endif
    end
  end

  always_comb begin
    serial     = serial_q;
    serial_oe  = active_q;
    busy       = active_q;
    block_done = done_q;
    underrun   = urun_q;
  end

endmodule

// File: tb/tb_dat_serializer.sv
// Scoreboard bench for dat_serializer: the driver queues the expected DAT stream per block, a monitor pops and compares.
module tb_dat_serializer;
  localparam int N  = 32;
  localparam int M  = 4;
  localparam int BW = 2;
`ifdef DAT_SERIALIZER_CRC16_EN
  localparam int CRC_CYC = 16;
`else
  localparam int CRC_CYC = 0;
`endif
  localparam int BLK_CYC = 2 + BW * (N / M) + CRC_CYC;
  localparam int EV_DONE = 1;
  localparam int EV_URUN = 2;

  logic         sd_clock = 1'b0;
  logic         reset    = 1'b0;
  logic         start    = 1'b0;
  logic [N-1:0] word_in  = '0;
  logic         word_valid = 1'b0;
  logic         word_ready;
  logic [M-1:0] serial;
  logic         serial_oe;
  logic         busy;
  logic         block_done;
  logic         underrun;

  dat_serializer #(.N(N), .M(M), .BLOCK_WORDS(BW)) dut (
    .sd_clock(sd_clock), .reset(reset), .start(start), .word_in(word_in),
    .word_valid(word_valid), .word_ready(word_ready), .serial(serial),
    .serial_oe(serial_oe), .busy(busy), .block_done(block_done), .underrun(underrun)
  );

  always #5 sd_clock = ~sd_clock;

  typedef struct packed {
    logic [1:0] kind;  // 0 start, 1 data, 2 crc, 3 stop
    logic [3:0] nib;
  } exp_t;

  exp_t         exp_q[$];
  int           ev_q[$];
  logic [N-1:0] loop_q[$];
  logic [N-1:0] blk_words[$];
  int           checks = 0;
  int           errors = 0;
  bit           mon_en = 1'b0;
  logic [N-1:0] asm_word = '0;
  int           asm_cnt  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

`ifdef DAT_SERIALIZER_CRC16_EN
  function automatic logic [15:0] line_crc(input int line, input int first);
    logic [15:0] c;
    logic [N-1:0] w;
    logic b;
    c = '0;
    for (int j = first; j < first + BW; j++) begin
      w = blk_words[j];
      for (int k = 0; k < N / M; k++) begin
        b = w[N - M - k * M + line];
        c = (c << 1) ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction
`endif

  // Expected bus stream for nblk blocks; global word index u is where the source fails to deliver.
  task automatic push_expect(input int nblk, input int u);
    logic [N-1:0] w;
    exp_t e;
    for (int b = 0; b < nblk; b++) begin
      e.kind = 2'd0; e.nib = 4'h0; exp_q.push_back(e);
      for (int j = 0; j < BW; j++) begin
        if (b * BW + j == u) begin
          ev_q.push_back(EV_URUN);
          return;
        end
        w = blk_words[b * BW + j];
        loop_q.push_back(w);
        for (int k = 0; k < N / M; k++) begin
          e.kind = 2'd1;
          e.nib  = w[N - 1 - k * M -: M];
          exp_q.push_back(e);
        end
      end
`ifdef DAT_SERIALIZER_CRC16_EN
      begin
        logic [15:0] c [M];
        for (int i = 0; i < M; i++) c[i] = line_crc(i, b * BW);
        for (int t = 0; t < 16; t++) begin
          e.kind = 2'd2;
          for (int i = 0; i < M; i++) e.nib[i] = c[i][15 - t];
          exp_q.push_back(e);
        end
      end
`endif
      e.kind = 2'd3; e.nib = 4'hF; exp_q.push_back(e);
      ev_q.push_back(EV_DONE);
    end
  endtask

  always @(negedge sd_clock) begin
    if (mon_en) begin
      exp_t e;
      if (block_done && underrun) chk("done_and_underrun", 1, 0);
      if (serial_oe) begin
        if (exp_q.size() == 0) chk("unexpected_oe", {28'h0, serial}, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("nibble", {28'h0, serial}, {28'h0, e.nib});
          if (e.kind == 2'd1) begin
            asm_word = {asm_word[N-M-1:0], serial};
            asm_cnt++;
            if (asm_cnt == N / M) begin
              asm_cnt = 0;
              if (loop_q.size() == 0) chk("loopback_extra", asm_word, 0);
              else chk("loopback_word", asm_word, loop_q.pop_front());
            end
          end
        end
      end else begin
        chk("idle_serial", {28'h0, serial}, 32'hF);
      end
      if (block_done) begin
        if (ev_q.size() == 0) chk("done_unexpected", 1, 0);
        else chk("event_done", EV_DONE, ev_q.pop_front());
      end
      if (underrun) begin
        if (ev_q.size() == 0) chk("underrun_unexpected", 1, 0);
        else chk("event_underrun", EV_URUN, ev_q.pop_front());
      end
    end
  end

  // Drives nblk blocks from blk_words; called and returns on a negedge.
  task automatic run_blocks(input int nblk, input int u, input bit pulses, input bit hold,
                            output int busy_cyc, output int gap);
    int idx, rises, total;
    bit prev, urun, finished;
    idx = 0; rises = 0; prev = 0; urun = 0; finished = 0;
    total = nblk * BW;
    busy_cyc = 0; gap = 0;
    push_expect(nblk, u);
    start = 1'b1;
    @(negedge sd_clock);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (busy && !prev) rises++;
      prev = busy;
      if (busy) busy_cyc++;
      if (!busy && rises == 1 && nblk > 1) gap++;
      if ((urun && !busy) || (rises == nblk && idx == total && !busy)) begin
        finished = 1;
        break;
      end
      if (word_ready) begin
        if (idx == u) begin
          word_valid = 1'b0;
          urun = 1'b1;
        end else begin
          word_valid = 1'b1;
          word_in = blk_words[idx];
          idx++;
        end
      end else begin
        word_valid = 1'($urandom_range(0, 1));
        word_in = $urandom;
      end
      if (hold) start = (rises < nblk);
      else start = pulses && !urun && busy && (idx < total) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge sd_clock);
    end
    if (!finished) chk("block_timeout", 1, 0);
    start = 1'b0;
    word_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, gp, u;
    reset = 1'b0;
    repeat (3) @(negedge sd_clock);
    chk("rst_serial", {28'h0, serial}, 32'hF);
    chk("rst_oe", serial_oe, 0);
    chk("rst_ready", word_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", block_done, 0);
    chk("rst_underrun", underrun, 0);
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge sd_clock);

    blk_words = '{32'h12345678, 32'h9ABCDEF0};
    run_blocks(1, BW, 1'b0, 1'b0, bc, gp);
    chk("busy_len_directed", bc, BLK_CYC);
    @(negedge sd_clock);

    blk_words = '{32'h0, 32'h0};
    run_blocks(1, BW, 1'b0, 1'b0, bc, gp);
    chk("busy_len_zero", bc, BLK_CYC);
    blk_words = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_blocks(1, BW, 1'b1, 1'b0, bc, gp);
    chk("busy_len_ones", bc, BLK_CYC);

    blk_words = '{32'h12345678, 32'h9ABCDEF0};
    run_blocks(1, 1, 1'b0, 1'b0, bc, gp);
    chk("underrun_w1_idle", busy, 0);

    for (int r = 0; r < 24; r++) begin
      blk_words = {};
      for (int j = 0; j < BW; j++) blk_words.push_back($urandom);
      u = ($urandom_range(0, 2) == 0) ? $urandom_range(0, BW - 1) : BW;
      run_blocks(1, u, 1'b1, 1'b0, bc, gp);
      if (u < BW) chk("underrun_idle", busy, 0);
      else chk("busy_len_rand", bc, BLK_CYC);
      repeat ($urandom_range(0, 3)) @(negedge sd_clock);
    end

    blk_words = {};
    for (int j = 0; j < 2 * BW; j++) blk_words.push_back($urandom);
    run_blocks(2, 2 * BW, 1'b0, 1'b1, bc, gp);
    chk("b2b_gap", gp, 1);

    repeat (4) @(negedge sd_clock);
    chk("exp_left", exp_q.size(), 0);
    chk("events_left", ev_q.size(), 0);
    chk("loop_left", loop_q.size(), 0);

    mon_en = 1'b0;
    start = 1'b1;
    @(negedge sd_clock);
    start = 1'b0;
    word_valid = 1'b1;
    word_in = 32'hA5A5_5A5A;
    repeat (5) @(negedge sd_clock);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_serial", {28'h0, serial}, 32'hF);
    chk("midrst_oe", serial_oe, 0);
    chk("midrst_busy", busy, 0);
    word_valid = 1'b0;
    exp_q = {}; ev_q = {}; loop_q = {}; asm_cnt = 0;
    @(negedge sd_clock);
    reset = 1'b1;
    repeat (3) @(negedge sd_clock);
    chk("post_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dat_serializer.md
# dat_serializer

Transmit-side DAT-line serializer for the SD host: converts a stream of N-bit parallel words into M-bit-wide nibbles on the DAT bus, one nibble per `sd_clock`. It is the write-path counterpart of the host's M-to-N DAT deserializer, using the same MSB-first nibble ordering so a looped-back bus reproduces the original words. It frames each block with a start nibble, a stop nibble and, optionally, per-line CRC16. It sits between the write data buffer and the DAT pad drivers.

## Interface
- `N`, 32, parallel word width; must be a multiple of `M`
- `M`, 4, DAT bus width (lines)
- `BLOCK_WORDS`, 128, words per block (128 × 32 bits = 512 bytes)

- `sd_clock`  in  1  sole clock; all logic on posedge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request block transmission; sampled in IDLE only
- `word_in`  in  N  parallel data word
- `word_valid`  in  1  `word_in` is valid
- `word_ready`  out  1  serializer accepts `word_in` on this edge
- `serial`  out  M  DAT line values
- `serial_oe`  out  1  DAT output enable
- `busy`  out  1  block in progress (state ≠ IDLE)
- `block_done`  out  1  one-cycle pulse after the stop nibble
- `underrun`  out  1  one-cycle pulse when a needed word was not valid

## Operation
- States: IDLE, START, DATA, CRC, STOP.
- IDLE: `serial`={M{1}}, `serial_oe`=0. `start`=1 → START.
- START (1 cycle): `serial`=0, `serial_oe`=1, `word_ready`=1. Handshake (`word_valid`&`word_ready`) loads the shift register → DATA. No handshake → IDLE with `underrun` pulse.
- DATA: nibble k of the current word = `word[N-1-k*M -: M]`, k = 0..N/M-1, MSB nibble first. `word_ready`=1 during the last nibble of each word except the final word of the block. Handshake loads the next word seamlessly; no handshake → IDLE with `underrun`, `serial_oe`=0 next cycle. After the last nibble of word BLOCK_WORDS-1 → CRC (macro on) or STOP.
- CRC: 16 cycles. Line i drives bit 15 first of its own CRC16 register.
- STOP (1 cycle): `serial`={M{1}}, `serial_oe`=1 → IDLE, with `block_done` pulsed during the first IDLE cycle.
- `start` outside IDLE is ignored. `word_valid` without `word_ready` is ignored; no data is consumed.
- Counters: nibble counter 0..N/M-1 wraps; word counter 0..BLOCK_WORDS-1; CRC counter 0..15. All are cleared on entering START.

## Timing
- All outputs are registered. Reset values: `serial`={M{1}}, `serial_oe`=0, `word_ready`=0, `busy`=0, `block_done`=0, `underrun`=0, state=IDLE, all counters and CRC registers 0.
- `start` sampled at edge t → start nibble during cycle t+1 → nibble 0 of word 0 during t+2.
- Block length from start nibble to stop nibble inclusive: 2 + BLOCK_WORDS·N/M (+16 with CRC).
- `word_ready` is combinational from state and counters, stable for the whole cycle. The upstream must present the next word within that single cycle; there is no stalling.
- Reset deasserted mid-block is not required to resume; reset asserted mid-block forces the reset values immediately (asynchronous).
- `underrun` and `block_done` are never high in the same cycle.

## Configuration
- `DAT_SERIALIZER_CRC16_EN` defined: one CRC16 per line, polynomial x^16+x^12+x^5+1, initialised to 0 at START, updated with every DATA bit on that line, shifted out in the CRC state.
- Macro undefined: no CRC state or registers; DATA goes directly to STOP, and the block is 16 cycles shorter.

## Test plan
- Reset: assert `reset`=0 mid-DATA → `serial`=4'hF, `serial_oe`=0, `busy`=0 in the same cycle.
- Single block, BLOCK_WORDS=2, words 32'h12345678 and 32'h9ABCDEF0 always valid → `serial` sequence 0,1,2,…,8,9,A,…,0,[CRC],F, then `block_done` pulse. Without CRC, `busy` is high for exactly 18 cycles.
- Loopback: feed `serial` during DATA into the M-to-N deserializer → words reproduced bit-exact.
- Underrun: drop `word_valid` at word 1 → `underrun` pulses once, `serial_oe`=0 on the next cycle, state IDLE, `block_done` never asserts.
- CRC (macro on): all-zero block of 512 bytes → every line's CRC = 16'h0000. A block of all 8'hFF bytes produces the per-line CRC given by the golden model.
- `start` held high continuously → back-to-back blocks separated by exactly one IDLE cycle; `start` pulses during DATA have no effect.
